// File: rtl/fp16_pkg.sv
// -----------------------------------------------------------------------------
// fp16_pkg
//   Shared binary16 definitions for the FPU divider: the packed operand
//   layout, format constants, the divider state encoding and the small
//   helpers used to unpack an operand and count leading zeros.
//   Build option: FP16_DIV_SUBNORMAL_EN (when undefined, subnormal operands
//   are unpacked as signed zero).
// -----------------------------------------------------------------------------
package fp16_pkg;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] man;
  } fp16_t;

  localparam int          FP16_BIAS = 15;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [14:0] FP16_INF  = 15'h7C00;

  // Unbiased exponents are carried as 7-bit two's complement values.
  localparam logic [6:0]  FP16_EMIN = 7'(1 - FP16_BIAS);  // -14
  localparam logic [6:0]  FP16_EMAX = 7'(FP16_BIAS);      // +15

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_NORM   = 3'd2,
    ST_DIVIDE = 3'd3,
    ST_ROUND  = 3'd4,
    ST_PACK   = 3'd5
  } div_state_t;

  // One operand after classification; man carries the hidden bit at [10].
  typedef struct packed {
    logic       nan;
    logic       inf;
    logic       zero;
    logic [6:0] exp;
    logic [10:0] man;
  } fp16_unpacked_t;

  function automatic fp16_unpacked_t fp16_unpack(input fp16_t x);
    fp16_unpacked_t u;
    logic exp_max;
    logic exp_min;
    exp_max = &x.exp;
    exp_min = ~|x.exp;
    u.nan   = exp_max & (|x.man);
    u.inf   = exp_max & ~(|x.man);
`ifdef FP16_DIV_SUBNORMAL_EN
    u.zero  = exp_min & ~(|x.man);
`else
    // Without subnormal support every denormal operand behaves as zero.
    u.zero  = exp_min;
`endif
    u.exp   = exp_min ? FP16_EMIN : ({2'b00, x.exp} - 7'(FP16_BIAS));
    u.man   = {~exp_min, x.man};
    return u;
  endfunction

  // Leading-zero count of an 11-bit mantissa (11 when the value is zero).
  function automatic logic [3:0] lzc11(input logic [10:0] v);
    logic [3:0] n;
    n = 4'd11;
    for (int i = 0; i < 11; i++) begin
      if (v[i]) n = 4'(10 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp16_div_step.sv
// -----------------------------------------------------------------------------
// fp16_div_step
//   One combinational restoring-division step. The partial remainder is
//   compared with the divisor; on success the divisor is subtracted and a 1
//   is retired, otherwise the remainder is kept. The result is shifted left
//   ready for the next step.
//   Ports:
//     rem       in  12  partial remainder (always < 2*divisor)
//     divisor   in  11  normalised divisor mantissa
//     rem_next  out 12  next partial remainder, already doubled
//     q_bit     out 1   retired quotient bit
// -----------------------------------------------------------------------------
module fp16_div_step (
  input  logic [11:0] rem,
  input  logic [10:0] divisor,
  output logic [11:0] rem_next,
  output logic        q_bit
);

  logic [12:0] diff;
  logic [11:0] kept;

  assign diff     = {1'b0, rem} - {2'b00, divisor};
  assign q_bit    = ~diff[12];
  assign kept     = q_bit ? diff[11:0] : rem;
  // After a successful subtract kept < divisor, so the top bit is never lost.
  assign rem_next = kept << 1;

endmodule

// File: rtl/fp16_divider.sv
// -----------------------------------------------------------------------------
// fp16_divider
//   IEEE754 binary16 divider, result = dataa / datab, round-to-nearest-even.
//   Multi-cycle FSM: IDLE -> UNPACK -> NORM -> DIVIDE x(14/BITS_PER_CYCLE)
//   -> ROUND -> PACK -> IDLE, with a restoring mantissa divider retiring
//   BITS_PER_CYCLE quotient bits per DIVIDE cycle.
//   Build option: FP16_DIV_SUBNORMAL_EN enables subnormal operands and
//   results; otherwise subnormal inputs are zero and tiny results flush.
//   Ports:
//     clock      in  1   rising-edge clock
//     reset      in  1   asynchronous reset, active-high
//     clk_en     in  1   start request, sampled only in IDLE
//     dataa      in  16  dividend
//     datab      in  16  divisor
//     result     out 16  quotient
//     sign       out 1   result[15]
//     overflow   out 1   finite result too large, forced to +/-inf
//     underflow  out 1   nonzero exact result delivered as zero
//     zero       out 1   result magnitude is zero
//     nan        out 1   result is the canonical NaN
//     divbyzero  out 1   finite nonzero divided by zero
//     busy       out 1   FSM not in IDLE
//     done       out 1   one-cycle pulse, result and flags valid
// -----------------------------------------------------------------------------
module fp16_divider
  import fp16_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clk_en,
  input  logic [15:0] dataa,
  input  logic [15:0] datab,
  output logic [15:0] result,
  output logic        sign,
  output logic        overflow,
  output logic        underflow,
  output logic        zero,
  output logic        nan,
  output logic        divbyzero,
  output logic        busy,
  output logic        done
);

  localparam int DIV_CYCLES = 14 / BITS_PER_CYCLE;

  generate
    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2) begin : g_bad_param
      $error("fp16_divider: BITS_PER_CYCLE must be 1 or 2");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State. Index 0 of every operand array is the dividend, 1 the divisor.
  // ---------------------------------------------------------------------------
  div_state_t  state_reg;
  fp16_t       op_reg [2];
  logic [1:0]  op_nan_reg;
  logic [1:0]  op_inf_reg;
  logic [1:0]  op_zero_reg;
  logic [6:0]  exp_reg [2];
  logic [10:0] man_reg [2];
  logic        sign_reg;
  logic [11:0] rem_reg;
  logic [13:0] q_reg;
  logic [6:0]  exp_q_reg;
  logic [3:0]  cnt_reg;
  logic [10:0] man_rnd_reg;
  logic [6:0]  exp_rnd_reg;
  logic [15:0] result_reg;
  logic        overflow_reg;
  logic        underflow_reg;
  logic        nan_reg;
  logic        divbyzero_reg;
  logic        done_reg;

  // ---------------------------------------------------------------------------
  // Per-operand unpack and normalisation
  // ---------------------------------------------------------------------------
  fp16_unpacked_t unp      [2];
  logic [10:0]    norm_man [2];
  logic [6:0]     norm_exp [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign unp[gi] = fp16_unpack(op_reg[gi]);
`ifdef FP16_DIV_SUBNORMAL_EN
      // Subnormals are left-justified in one step; normals have lz == 0.
      logic [3:0] lz;
      assign lz           = lzc11(man_reg[gi]);
      assign norm_man[gi] = man_reg[gi] << lz;
      assign norm_exp[gi] = exp_reg[gi] - {3'b000, lz};
`else
      assign norm_man[gi] = man_reg[gi];
      assign norm_exp[gi] = exp_reg[gi];
`endif
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Restoring divider chain: BITS_PER_CYCLE steps per clock, MSB first.
  // ---------------------------------------------------------------------------
  logic [11:0]               chain_rem [BITS_PER_CYCLE + 1];
  logic [BITS_PER_CYCLE-1:0] q_bits;

  assign chain_rem[0] = rem_reg;

  generate
    for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      fp16_div_step u_step (
        .rem      (chain_rem[gi]),
        .divisor  (man_reg[1]),
        .rem_next (chain_rem[gi+1]),
        .q_bit    (q_bits[BITS_PER_CYCLE-1-gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round: pick the 11-bit mantissa from the 14-bit quotient, optionally
  // denormalise, then round to nearest even.
  // ---------------------------------------------------------------------------
  logic [10:0] rnd_man;
  logic        rnd_g;
  logic        rnd_r;
  logic        rnd_s;
  logic [6:0]  rnd_exp;
  logic        rnd_inc;
  logic [11:0] rnd_sum;
  logic [10:0] rnd_man_out;
  logic [6:0]  rnd_exp_out;
`ifdef FP16_DIV_SUBNORMAL_EN
  logic [6:0]  sub_sh_full;
  logic [3:0]  sub_sh;
  logic [12:0] sub_ext;
  logic [12:0] sub_mask;
`endif

  always_comb begin
    rnd_man     = q_reg[12:2];
    rnd_g       = q_reg[1];
    rnd_r       = q_reg[0];
    rnd_s       = |rem_reg;
    rnd_exp     = exp_q_reg - 7'd1;
    rnd_inc     = 1'b0;
    rnd_sum     = 12'd0;
    rnd_man_out = 11'd0;
    rnd_exp_out = 7'd0;
`ifdef FP16_DIV_SUBNORMAL_EN
    sub_sh_full = 7'd0;
    sub_sh      = 4'd0;
    sub_ext     = 13'd0;
    sub_mask    = 13'd0;
`endif

    if (q_reg[13]) begin
      rnd_man = q_reg[13:3];
      rnd_g   = q_reg[2];
      rnd_r   = q_reg[1];
      rnd_s   = q_reg[0] | (|rem_reg);
      rnd_exp = exp_q_reg;
    end

`ifdef FP16_DIV_SUBNORMAL_EN
    // Too small for a normal: shift into subnormal position at exp -14,
    // folding every bit that falls off the guard/round pair into sticky.
    if ($signed(rnd_exp) < $signed(FP16_EMIN)) begin
      sub_sh_full = FP16_EMIN - rnd_exp;
      sub_sh      = (sub_sh_full > 7'd13) ? 4'd13 : sub_sh_full[3:0];
      sub_ext     = {rnd_man, rnd_g, rnd_r};
      sub_mask    = (13'd1 << sub_sh) - 13'd1;
      rnd_s       = rnd_s | (|(sub_ext & sub_mask));
      sub_ext     = sub_ext >> sub_sh;
      rnd_man     = sub_ext[12:2];
      rnd_g       = sub_ext[1];
      rnd_r       = sub_ext[0];
      rnd_exp     = FP16_EMIN;
    end
`endif

    rnd_inc = rnd_g & (rnd_r | rnd_s | rnd_man[0]);
    rnd_sum = {1'b0, rnd_man} + {11'd0, rnd_inc};
    if (rnd_sum[11]) begin
      // 0x7FF rounded up to 0x800: renormalise to 1.0 at the next exponent.
      rnd_man_out = rnd_sum[11:1];
      rnd_exp_out = rnd_exp + 7'd1;
    end else begin
      rnd_man_out = rnd_sum[10:0];
      rnd_exp_out = rnd_exp;
    end
  end

  // ---------------------------------------------------------------------------
  // Pack: special cases first, in priority order, then the finite result.
  // ---------------------------------------------------------------------------
  logic [15:0] pk_result;
  logic        pk_overflow;
  logic        pk_underflow;
  logic        pk_nan;
  logic        pk_divbyzero;
  logic [4:0]  pk_biased;

  // Low five bits suffice: the biased exponent is only used when in range.
  assign pk_biased = exp_rnd_reg[4:0] + 5'(FP16_BIAS);

  always_comb begin
    pk_result    = {sign_reg, 15'h0000};
    pk_overflow  = 1'b0;
    pk_underflow = 1'b0;
    pk_nan       = 1'b0;
    pk_divbyzero = 1'b0;

    if (|op_nan_reg) begin
      pk_result = FP16_QNAN;
      pk_nan    = 1'b1;
    end else if ((&op_zero_reg) || (&op_inf_reg)) begin
      pk_result = FP16_QNAN;
      pk_nan    = 1'b1;
    end else if (op_inf_reg[0]) begin
      pk_result = {sign_reg, FP16_INF};
    end else if (op_zero_reg[1]) begin
      pk_result    = {sign_reg, FP16_INF};
      pk_divbyzero = 1'b1;
    end else if (op_zero_reg[0] || op_inf_reg[1]) begin
      pk_result = {sign_reg, 15'h0000};
    end else if ($signed(exp_rnd_reg) > $signed(FP16_EMAX)) begin
      pk_result   = {sign_reg, FP16_INF};
      pk_overflow = 1'b1;
    end else begin
`ifdef FP16_DIV_SUBNORMAL_EN
      if (man_rnd_reg[10]) begin
        pk_result = {sign_reg, pk_biased, man_rnd_reg[9:0]};
      end else begin
        // Subnormal encoding; both operands are nonzero here, so a zero
        // mantissa means the whole quotient was rounded away.
        pk_result    = {sign_reg, 5'd0, man_rnd_reg[9:0]};
        pk_underflow = ~(|man_rnd_reg);
      end
`else
      if (($signed(exp_rnd_reg) < $signed(FP16_EMIN)) || !man_rnd_reg[10]) begin
        pk_result    = {sign_reg, 15'h0000};
        pk_underflow = 1'b1;
      end else begin
        pk_result = {sign_reg, pk_biased, man_rnd_reg[9:0]};
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      for (int i = 0; i < 2; i++) begin
        op_reg[i]  <= '0;
        exp_reg[i] <= 7'd0;
        man_reg[i] <= 11'd0;
      end
      op_nan_reg    <= 2'b00;
      op_inf_reg    <= 2'b00;
      op_zero_reg   <= 2'b00;
      sign_reg      <= 1'b0;
      rem_reg       <= 12'd0;
      q_reg         <= 14'd0;
      exp_q_reg     <= 7'd0;
      cnt_reg       <= 4'd0;
      man_rnd_reg   <= 11'd0;
      exp_rnd_reg   <= 7'd0;
      result_reg    <= 16'h0000;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      nan_reg       <= 1'b0;
      divbyzero_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (clk_en) begin
            op_reg[0] <= dataa;
            op_reg[1] <= datab;
            state_reg <= ST_UNPACK;
          end
        end

        ST_UNPACK: begin
          sign_reg <= op_reg[0].sign ^ op_reg[1].sign;
          for (int i = 0; i < 2; i++) begin
            op_nan_reg[i]  <= unp[i].nan;
            op_inf_reg[i]  <= unp[i].inf;
            op_zero_reg[i] <= unp[i].zero;
            exp_reg[i]     <= unp[i].exp;
            man_reg[i]     <= unp[i].man;
          end
          state_reg <= ST_NORM;
        end

        ST_NORM: begin
          man_reg[0] <= norm_man[0];
          man_reg[1] <= norm_man[1];
          rem_reg    <= {1'b0, norm_man[0]};
          exp_q_reg  <= norm_exp[0] - norm_exp[1];
          q_reg      <= 14'd0;
          cnt_reg    <= 4'd0;
          state_reg  <= ST_DIVIDE;
        end

        ST_DIVIDE: begin
          rem_reg <= chain_rem[BITS_PER_CYCLE];
          q_reg   <= {q_reg[13-BITS_PER_CYCLE:0], q_bits};
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == 4'(DIV_CYCLES - 1)) begin
            state_reg <= ST_ROUND;
          end
        end

        ST_ROUND: begin
          man_rnd_reg <= rnd_man_out;
          exp_rnd_reg <= rnd_exp_out;
          state_reg   <= ST_PACK;
        end

        ST_PACK: begin
          result_reg    <= pk_result;
          overflow_reg  <= pk_overflow;
          underflow_reg <= pk_underflow;
          nan_reg       <= pk_nan;
          divbyzero_reg <= pk_divbyzero;
          done_reg      <= 1'b1;
          state_reg     <= ST_IDLE;
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign result    = result_reg;
  assign sign      = result_reg[15];
  assign zero      = ~(|result_reg[14:0]);
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
  assign nan       = nan_reg;
  assign divbyzero = divbyzero_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;

endmodule
